pipe_stage_reg_hs: RTL and testbench



---
 rtl/pipe_stage_reg_hs.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_reg_hs.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg_hs.sv
// Valid/ready pipeline stage register with an optional 2-entry skid buffer,
// flush-to-bubble and a saturating count of squashed entries.
module pipe_stage_reg_hs #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int RD_W   = 5,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [RD_W-1:0]   out_rd,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [RD_W-1:0]   main_rd_q, main_rd_d, skid_rd_q, skid_rd_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  drop_count_q, drop_count_d;
    logic              in_fire, out_fire;
    logic [1:0]        drop_inc;
    logic [CNT_W:0]    drop_sum;

    assign out_valid  = (state_q != EMPTY);
    assign in_ready   = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign out_data   = main_data_q;
    assign out_ctrl   = main_ctrl_q;
    assign out_rd     = main_rd_q;
    assign occupancy  = state_q;
    assign drop_count = drop_count_q;

    // Entries lost to a flush: those held minus the one leaving, plus any offered.
    assign drop_inc = occupancy - {1'b0, out_fire} + {1'b0, in_valid};
    assign drop_sum = {1'b0, drop_count_q} + {{(CNT_W-1){1'b0}}, drop_inc};

    always_comb begin
        state_d      = state_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        main_rd_d    = main_rd_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_rd_d    = skid_rd_q;
        drop_count_d = drop_count_q;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                    main_rd_d   = in_rd;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (out_fire) begin
                    if (in_fire) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        main_rd_d   = in_rd;
                    end else begin
                        main_data_d = '0;
                        main_ctrl_d = '0;
                        main_rd_d   = '0;
                        state_d     = EMPTY;
                    end
                end else if (in_fire && SKID != 0) begin
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                    skid_rd_d   = in_rd;
                    state_d     = TWO;
                end
            end
            TWO: begin
                if (out_fire) begin
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                    main_rd_d   = skid_rd_q;
                    skid_data_d = '0;
                    skid_ctrl_d = '0;
                    skid_rd_d   = '0;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush overrides every transition; an out_fire this cycle still counts as delivered.
        if (flush) begin
            state_d     = EMPTY;
            main_data_d = '0;
            main_ctrl_d = '0;
            main_rd_d   = '0;
            skid_data_d = '0;
            skid_ctrl_d = '0;
            skid_rd_d   = '0;
            if (drop_sum[CNT_W]) drop_count_d = '1;
            else                 drop_count_d = drop_sum[CNT_W-1:0];
        end

        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EMPTY;
            main_data_q  <= '0;
            main_ctrl_q  <= '0;
            main_rd_q    <= '0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
            skid_rd_q    <= '0;
            in_ready_q   <= 1'b1;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            main_rd_q    <= main_rd_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_rd_q    <= skid_rd_d;
            in_ready_q   <= in_ready_d;
            drop_count_q <= drop_count_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg_hs.sv
// Scoreboard bench for pipe_stage_reg_hs: a skid instance, a narrow-counter
// skid instance and a single-entry instance share one stimulus stream.
module tb_pipe_stage_reg_hs;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  c;
        logic [4:0]  r;
    } ent_t;

    logic        clk = 0;
    logic        reset, flush, in_valid, out_ready;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic [4:0]  in_rd;

    logic        a_in_ready, a_out_valid;
    logic [63:0] a_data;
    logic [7:0]  a_ctrl;
    logic [4:0]  a_rd;
    logic [1:0]  a_occ;
    logic [15:0] a_drop;

    logic        s_in_ready, s_out_valid;
    logic [63:0] s_data;
    logic [7:0]  s_ctrl;
    logic [4:0]  s_rd;
    logic [1:0]  s_occ;
    logic [1:0]  s_drop;

    logic        n_in_ready, n_out_valid;
    logic [63:0] n_data;
    logic [7:0]  n_ctrl;
    logic [4:0]  n_rd;
    logic [1:0]  n_occ;
    logic [15:0] n_drop;

    ent_t q[$];
    ent_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_hs #(.SKID(1), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_rd(in_rd),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_data), .out_ctrl(a_ctrl), .out_rd(a_rd),
        .occupancy(a_occ), .drop_count(a_drop));

    pipe_stage_reg_hs #(.SKID(1), .CNT_W(2)) u_s (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_rd(in_rd),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_data), .out_ctrl(s_ctrl), .out_rd(s_rd),
        .occupancy(s_occ), .drop_count(s_drop));

    pipe_stage_reg_hs #(.SKID(0), .CNT_W(16)) u_n (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_rd(in_rd),
        .out_valid(n_out_valid), .out_ready(out_ready),
        .out_data(n_data), .out_ctrl(n_ctrl), .out_rd(n_rd),
        .occupancy(n_occ), .drop_count(n_drop));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] c, input logic [4:0] r);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
        in_rd    = r;
    endtask

    task automatic do_reset();
        reset = 1; flush = 0; out_ready = 0;
        drive(1, 64'hdead, 8'hff, 5'd31);
        cyc();
        reset = 0;
        drive(0, 0, 0, 0);
        #1;
        q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b want 0", a_out_valid); end
        n_cmp++; if ({a_data, a_ctrl, a_rd} !== '0) begin n_bad++; $display("FAIL reset_payload: got %h want 0", {a_data, a_ctrl, a_rd}); end
        n_cmp++; if (a_occ !== 2'd0) begin n_bad++; $display("FAIL reset_occ: got %0d want 0", a_occ); end
        n_cmp++; if (a_drop !== 16'd0) begin n_bad++; $display("FAIL reset_drop: got %0d want 0", a_drop); end
        n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0b want 1", a_in_ready); end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1;
        drive(1, 64'h1234, 8'h05, 5'd7);
        q.push_back('{64'h1234, 8'h05, 5'd7});
        cyc();
        drive(0, 0, 0, 0);
        n_cmp++; if (a_out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %0b want 1", a_out_valid); end
        e = q.pop_front();
        n_cmp++; if ({a_data, a_ctrl, a_rd} !== e) begin n_bad++; $display("FAIL single_payload: got %h want %h", {a_data, a_ctrl, a_rd}, e); end
        cyc();
        n_cmp++; if (a_out_valid !== 1'b0 || a_ctrl !== 8'h00 || a_data !== 64'h0) begin
            n_bad++; $display("FAIL single_bubble: got v=%0b c=%h d=%h want 0/00/0", a_out_valid, a_ctrl, a_data); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 0;
        drive(1, 64'h11, 8'h01, 5'd1);
        q.push_back('{64'h11, 8'h01, 5'd1});
        cyc();
        drive(1, 64'h22, 8'h02, 5'd2);
        n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_one: got %0b want 1", a_in_ready); end
        q.push_back('{64'h22, 8'h02, 5'd2});
        cyc();
        drive(0, 0, 0, 0);
        n_cmp++; if (a_occ !== 2'd2) begin n_bad++; $display("FAIL bp_occ: got %0d want 2", a_occ); end
        n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %0b want 0", a_in_ready); end
        cyc();
        n_cmp++; if (a_data !== 64'h11 || a_out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_stable: got v=%0b d=%h want 1/11", a_out_valid, a_data); end
        out_ready = 1;
        #1;
        for (int i = 0; i < 2; i++) begin
            e = q.pop_front();
            n_cmp++; if (a_out_valid !== 1'b1 || {a_data, a_ctrl, a_rd} !== e) begin
                n_bad++; $display("FAIL bp_drain%0d: got v=%0b %h want 1 %h", i, a_out_valid, {a_data, a_ctrl, a_rd}, e); end
            cyc();
        end
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %0b want 0", a_out_valid); end
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 64'(i), 8'(i + 8'h10), 5'(i));
            q.push_back('{64'(i), 8'(i + 8'h10), 5'(i)});
            cyc();
            e = q.pop_front();
            n_cmp++; if (a_out_valid !== 1'b1 || {a_data, a_ctrl, a_rd} !== e || a_occ !== 2'd1) begin
                n_bad++; $display("FAIL stream%0d: got v=%0b occ=%0d %h want 1/1 %h", i, a_out_valid, a_occ, {a_data, a_ctrl, a_rd}, e); end
        end
        drive(0, 0, 0, 0);
        cyc();
        n_cmp++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin n_bad++; $display("FAIL stream_end: got v=%0b occ=%0d want 0/0", a_out_valid, a_occ); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 0;
        drive(1, 64'h11, 8'h01, 5'd1); cyc();
        drive(1, 64'h22, 8'h02, 5'd2); cyc();
        drive(1, 64'h33, 8'h03, 5'd3);
        flush = 1;
        cyc();
        flush = 0;
        drive(0, 0, 0, 0);
        n_cmp++; if (a_out_valid !== 1'b0 || a_ctrl !== 8'h00 || a_occ !== 2'd0) begin
            n_bad++; $display("FAIL flush_bubble: got v=%0b c=%h occ=%0d want 0/00/0", a_out_valid, a_ctrl, a_occ); end
        n_cmp++; if (a_drop !== 16'd3) begin n_bad++; $display("FAIL flush_drop3: got %0d want 3", a_drop); end
        n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %0b want 1", a_in_ready); end
        drive(1, 64'h44, 8'h04, 5'd4); cyc();
        drive(0, 0, 0, 0);
        out_ready = 1;
        flush = 1;
        #1;
        n_cmp++; if (a_out_valid !== 1'b1 || a_data !== 64'h44) begin n_bad++; $display("FAIL flush_xfer: got v=%0b d=%h want 1/44", a_out_valid, a_data); end
        cyc();
        flush = 0;
        n_cmp++; if (a_drop !== 16'd3 || a_out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_nodrop: got drop=%0d v=%0b want 3/0", a_drop, a_out_valid); end
    endtask

    task automatic test_saturation();
        int exp;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            out_ready = 0;
            drive(1, 64'(k), 8'h01, 5'd1); cyc();
            drive(1, 64'(k + 16), 8'h02, 5'd2); cyc();
            drive(0, 0, 0, 0);
            flush = 1;
            cyc();
            flush = 0;
            exp = (2 * k > 3) ? 3 : 2 * k;
            n_cmp++; if (s_drop !== 2'(exp)) begin n_bad++; $display("FAIL sat_drop%0d: got %0d want %0d", k, s_drop, exp); end
            n_cmp++; if (a_drop !== 16'(2 * k)) begin n_bad++; $display("FAIL wide_drop%0d: got %0d want %0d", k, a_drop, 2 * k); end
        end
    endtask

    task automatic test_noskid();
        do_reset();
        out_ready = 0;
        drive(1, 64'h55, 8'h05, 5'd5);
        #1;
        n_cmp++; if (n_in_ready !== 1'b1) begin n_bad++; $display("FAIL ns_ready_empty: got %0b want 1", n_in_ready); end
        q.push_back('{64'h55, 8'h05, 5'd5});
        cyc();
        drive(1, 64'h66, 8'h06, 5'd6);
        #1;
        n_cmp++; if (n_in_ready !== 1'b0) begin n_bad++; $display("FAIL ns_ready_full: got %0b want 0", n_in_ready); end
        cyc();
        n_cmp++; if (n_data !== 64'h55 || n_occ !== 2'd1) begin n_bad++; $display("FAIL ns_hold: got d=%h occ=%0d want 55/1", n_data, n_occ); end
        out_ready = 1;
        #1;
        n_cmp++; if (n_in_ready !== 1'b1) begin n_bad++; $display("FAIL ns_ready_comb: got %0b want 1", n_in_ready); end
        q.push_back('{64'h66, 8'h06, 5'd6});
        e = q.pop_front();
        n_cmp++; if (n_out_valid !== 1'b1 || {n_data, n_ctrl, n_rd} !== e) begin n_bad++; $display("FAIL ns_out0: got %h want %h", {n_data, n_ctrl, n_rd}, e); end
        cyc();
        drive(1, 64'h77, 8'h07, 5'd7);
        q.push_back('{64'h77, 8'h07, 5'd7});
        e = q.pop_front();
        n_cmp++; if (n_out_valid !== 1'b1 || {n_data, n_ctrl, n_rd} !== e) begin n_bad++; $display("FAIL ns_out1: got %h want %h", {n_data, n_ctrl, n_rd}, e); end
        cyc();
        drive(0, 0, 0, 0);
        out_ready = 0;
        e = q.pop_front();
        n_cmp++; if (n_out_valid !== 1'b1 || {n_data, n_ctrl, n_rd} !== e) begin n_bad++; $display("FAIL ns_out2: got %h want %h", {n_data, n_ctrl, n_rd}, e); end
        cyc();
        n_cmp++; if (n_occ !== 2'd1) begin n_bad++; $display("FAIL ns_occ: got %0d want 1", n_occ); end
        reset = 1;
        drive(1, 64'h88, 8'h08, 5'd8);
        cyc();
        reset = 0;
        drive(0, 0, 0, 0);
        n_cmp++; if ({n_out_valid, n_data, n_ctrl, n_rd, n_occ, n_drop} !== '0) begin
            n_bad++; $display("FAIL ns_reset: got v=%0b d=%h occ=%0d want all 0", n_out_valid, n_data, n_occ); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; flush = 0; out_ready = 0;
        drive(0, 0, 0, 0);
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_flush();
        test_saturation();
        test_noskid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
